// File: rtl/mem_issue_queue_pkg.sv
// Utilities: shared memory-op types and helpers.
//   mem_op_e  - memory opcode (LOAD/STORE/CLFLUSH/MNOP). Other 3-bit codes
//               may appear on the bus; they are carried unchanged.
//   alu_inp_t - issued instruction with resolved source operands.
//   is_store  - true when the instruction is a STORE.
package Utilities;

  typedef enum logic [2:0] {
    MNOP    = 3'd0,
    LOAD    = 3'd1,
    STORE   = 3'd2,
    CLFLUSH = 3'd3
  } mem_op_e;

  typedef struct packed {
    mem_op_e     op;
    logic [31:0] src0_val;
    logic [31:0] src1_val;
  } alu_inp_t;

  function automatic logic is_store(input alu_inp_t inst);
    return inst.op == STORE;
  endfunction

endpackage

// File: rtl/mem_issue_queue.sv
// mem_issue_queue: strict-FIFO issue queue between the operand-resolve stage
// and the memory stage.
//   clk, reset      - rising-edge clock; asynchronous active-low reset
//   enq_valid/inst  - upstream offer; accepted when enq_ready
//   enq_ready       - !full && !flush (no pass-through when full)
//   flush           - discard every queued entry; wins over enq and deq
//   mem_busy        - memory stage busy, combinational in the same cycle
//   mem_in_ready    - head is presented and popped this cycle
//   mem_inst        - head entry (stale/undefined while empty)
//   count           - valid entries; store_count - valid STORE entries
//   empty, full     - count==0, count==DEPTH
// DEPTH must be a power of two in 2..16.
module mem_issue_queue
  import Utilities::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  alu_inp_t                 enq_inst,
  output logic                     enq_ready,
  input  logic                     flush,
  input  logic                     mem_busy,
  output logic                     mem_in_ready,
  output alu_inp_t                 mem_inst,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   store_count,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  alu_inp_t        mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            do_enq;
  logic            do_deq;
  logic            enq_st;
  logic            deq_st;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // Gating with reset keeps both handshakes low while reset is held, even
  // though the registered state alone would already force mem_in_ready low.
  assign enq_ready    = reset && !full && !flush;
  assign mem_in_ready = reset && !empty && !mem_busy && !flush;

  assign do_enq = enq_valid && enq_ready;
  assign do_deq = mem_in_ready;
  assign enq_st = do_enq && is_store(enq_inst);
  assign deq_st = do_deq && is_store(mem_inst);

  assign mem_inst = mem[rd_ptr];

  // Entry storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem[wr_ptr] <= enq_inst;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_enq) wr_ptr <= wr_ptr + PW'(1);
      if (do_deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_enq, do_deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_count <= '0;
    end else if (flush) begin
      store_count <= '0;
    end else begin
      case ({enq_st, deq_st})
        2'b10:   store_count <= store_count + CW'(1);
        2'b01:   store_count <= store_count - CW'(1);
        default: store_count <= store_count;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
module tb_mem_issue_queue;
  import Utilities::*;

  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic       enq_valid;
  alu_inp_t   enq_inst;
  logic       enq_ready;
  logic       flush;
  logic       mem_busy;
  logic       mem_in_ready;
  alu_inp_t   mem_inst;
  logic [2:0] count;
  logic [2:0] store_count;
  logic       empty;
  logic       full;

  int n_vec = 0;
  int n_bad = 0;

  alu_inp_t sb[$];

  mem_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enq_valid    (enq_valid),
    .enq_inst     (enq_inst),
    .enq_ready    (enq_ready),
    .flush        (flush),
    .mem_busy     (mem_busy),
    .mem_in_ready (mem_in_ready),
    .mem_inst     (mem_inst),
    .count        (count),
    .store_count  (store_count),
    .empty        (empty),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic alu_inp_t mk(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_inp_t r;
    r.op       = mem_op_e'(op);
    r.src0_val = a;
    r.src1_val = b;
    return r;
  endfunction

  function automatic int sb_stores();
    int n = 0;
    foreach (sb[i]) if (sb[i].op == STORE) n++;
    return n;
  endfunction

  // Monitor/scoreboard: the model decides what the handshakes must be from
  // the queue contents and the inputs, then pops/pushes accordingly.
  always @(negedge clk) begin
    logic exp_er;
    logic exp_mir;
    alu_inp_t head;
    if (!reset) begin
      sb.delete();
    end else begin
      exp_er  = (sb.size() < DEPTH) && !flush;
      exp_mir = (sb.size() != 0) && !mem_busy && !flush;
      chk("enq_ready", 128'(enq_ready), 128'(exp_er));
      chk("mem_in_ready", 128'(mem_in_ready), 128'(exp_mir));
      chk("count", 128'(count), 128'(sb.size()));
      chk("store_count", 128'(store_count), 128'(sb_stores()));
      chk("empty", 128'(empty), 128'(sb.size() == 0));
      chk("full", 128'(full), 128'(sb.size() == DEPTH));
      if (exp_mir) begin
        head = sb.pop_front();
        chk("mem_inst", 128'(mem_inst), 128'(head));
      end
      if (flush) sb.delete();
      else if (enq_valid && exp_er) sb.push_back(enq_inst);
    end
  end

  task automatic cyc(input logic v, input alu_inp_t i, input logic b, input logic f);
    enq_valid = v;
    enq_inst  = i;
    mem_busy  = b;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  task automatic push_hold(input alu_inp_t inst, input logic busy);
    logic acc;
    int   n;
    n   = 0;
    acc = 1'b0;
    enq_valid = 1'b1;
    enq_inst  = inst;
    mem_busy  = busy;
    flush     = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = enq_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_vec++;
      n_bad++;
      $display("FAIL push_timeout: got not-accepted expected accepted at %0t", $time);
    end
    enq_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    alu_inp_t z;
    z = mk(3'd0, 32'd0, 32'd0);
    reset = 1'b0; enq_valid = 1'b0; enq_inst = z; flush = 1'b0; mem_busy = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_store_count", 128'(store_count), 128'(0));
    chk("rst_empty", 128'(empty), 128'(1));
    chk("rst_full", 128'(full), 128'(0));
    chk("rst_enq_ready", 128'(enq_ready), 128'(0));
    chk("rst_mem_in_ready", 128'(mem_in_ready), 128'(0));
    #3 reset = 1'b1;
    @(posedge clk); #1;

    // LOAD A, STORE B, LOAD C back to back, memory idle
    cyc(1'b1, mk(3'd1, 32'hA, 32'h1), 1'b0, 1'b0);
    chk("abc_sc0", 128'(store_count), 128'(0));
    chk("abc_mir_after_A", 128'(mem_in_ready), 128'(1));
    cyc(1'b1, mk(3'd2, 32'hB, 32'h2), 1'b0, 1'b0);
    chk("abc_sc1", 128'(store_count), 128'(1));
    cyc(1'b1, mk(3'd1, 32'hC, 32'h3), 1'b0, 1'b0);
    chk("abc_sc2", 128'(store_count), 128'(0));
    chk("abc_count", 128'(count), 128'(1));
    cyc(1'b0, z, 1'b0, 1'b0);
    chk("abc_empty", 128'(empty), 128'(1));

    // busy memory: fill, hold the 5th, release
    for (int k = 0; k < 4; k++) cyc(1'b1, mk(3'd1, 32'h10 + k, 32'h0), 1'b1, 1'b0);
    enq_inst = mk(3'd2, 32'h14, 32'h0);
    #1;
    chk("bsy_full", 128'(full), 128'(1));
    chk("bsy_count", 128'(count), 128'(4));
    chk("bsy_enq_ready", 128'(enq_ready), 128'(0));
    cyc(1'b1, mk(3'd2, 32'h14, 32'h0), 1'b1, 1'b0);
    chk("bsy_hold_count", 128'(count), 128'(4));
    cyc(1'b1, mk(3'd2, 32'h14, 32'h0), 1'b0, 1'b0);
    chk("bsy_first_pop", 128'(count), 128'(3));
    cyc(1'b1, mk(3'd2, 32'h14, 32'h0), 1'b0, 1'b0);
    chk("bsy_5th_in", 128'(count), 128'(3));
    chk("bsy_5th_store", 128'(store_count), 128'(1));
    for (int k = 0; k < 3; k++) cyc(1'b0, z, 1'b0, 1'b0);
    chk("bsy_drained", 128'(count), 128'(0));

    // full then streaming across pointer wrap; one pop per cycle
    for (int k = 0; k < 4; k++) cyc(1'b1, mk(3'd3, 32'h20 + k, 32'h0), 1'b1, 1'b0);
    for (int k = 0; k < 20; k++)
      push_hold(mk((k % 2 == 0) ? 3'd2 : 3'd7, 32'h100 + k, 32'(k)), 1'b0);
    // the full cycle cannot refill, so steady streaming keeps 3 entries
    chk("wrap_count", 128'(count), 128'(3));
    for (int k = 0; k < 3; k++) cyc(1'b0, z, 1'b0, 1'b0);
    chk("wrap_drained", 128'(empty), 128'(1));

    // flush with 3 entries (2 STOREs), enq offered, memory idle
    cyc(1'b1, mk(3'd1, 32'h30, 32'h0), 1'b1, 1'b0);
    cyc(1'b1, mk(3'd2, 32'h31, 32'h0), 1'b1, 1'b0);
    cyc(1'b1, mk(3'd2, 32'h32, 32'h0), 1'b1, 1'b0);
    chk("fl_pre_sc", 128'(store_count), 128'(2));
    enq_valid = 1'b1; enq_inst = mk(3'd2, 32'h33, 32'h0); mem_busy = 1'b0; flush = 1'b1;
    #1;
    chk("fl_enq_ready", 128'(enq_ready), 128'(0));
    chk("fl_mir", 128'(mem_in_ready), 128'(0));
    @(posedge clk); #1;
    flush = 1'b0; enq_valid = 1'b0;
    chk("fl_count", 128'(count), 128'(0));
    chk("fl_sc", 128'(store_count), 128'(0));
    chk("fl_empty", 128'(empty), 128'(1));

    // async reset mid-stream with 2 entries queued
    cyc(1'b1, mk(3'd2, 32'h40, 32'h0), 1'b1, 1'b0);
    cyc(1'b1, mk(3'd1, 32'h41, 32'h0), 1'b1, 1'b0);
    enq_valid = 1'b0; mem_busy = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("ar_count", 128'(count), 128'(0));
    chk("ar_sc", 128'(store_count), 128'(0));
    chk("ar_empty", 128'(empty), 128'(1));
    chk("ar_full", 128'(full), 128'(0));
    chk("ar_enq_ready", 128'(enq_ready), 128'(0));
    chk("ar_mir", 128'(mem_in_ready), 128'(0));
    @(posedge clk); #2 reset = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, mk(3'd1, 32'h50, 32'h0), 1'b0, 1'b0);
    chk("ar_first_enq", 128'(count), 128'(1));
    chk("ar_issue", 128'(mem_in_ready), 128'(1));
    cyc(1'b0, z, 1'b0, 1'b0);

    // random busy/enqueue traffic, checked by the scoreboard
    for (int k = 0; k < 1000; k++) begin
      logic [2:0] op;
      case ($urandom_range(0, 4))
        0: op = 3'd0;
        1: op = 3'd1;
        2: op = 3'd2;
        3: op = 3'd3;
        default: op = 3'd7;
      endcase
      cyc(1'($urandom_range(0, 1)), mk(op, $urandom, $urandom), 1'($urandom_range(0, 1)), 1'b0);
    end
    for (int k = 0; k < 8; k++) cyc(1'b0, z, 1'b0, 1'b0);
    chk("rnd_drained", 128'(count), 128'(0));
    chk("rnd_sb_empty", 128'(sb.size()), 128'(count));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
